// File: rtl/cpu_control_fsm_pkg.sv
// cpu_control_fsm_pkg: opcodes, state encoding and instruction field positions for the control FSM
package cpu_control_fsm_pkg;
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_CMP = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JC  = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_JN  = 4'hB;
   localparam logic [3:0] OP_JP  = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hF;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_e;
   function automatic logic writes_acc(input logic [3:0] op);
      return (op >= OP_LDI) && (op <= OP_XOR);
   endfunction
   function automatic logic writes_flags(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_CMP);
   endfunction
endpackage

// File: rtl/cpu_control_fsm_branch_cond.sv
// branch_cond: decides whether the current opcode is a taken branch given the flag inputs
module branch_cond
   import cpu_control_fsm_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       C,
   input  logic       N,
   input  logic       P,
   input  logic       Z,
   output logic       taken
);
   always_comb
      taken = (opcode == OP_JMP) | ((opcode == OP_JC) & C) | ((opcode == OP_JZ) & Z) |
              ((opcode == OP_JN) & N) | ((opcode == OP_JP) & P);
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: fetch/decode/execute sequencer owning the program counter and instruction register
module cpu_control_fsm
   import cpu_control_fsm_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   C,
   input  logic                   N,
   input  logic                   P,
   input  logic                   Z,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [3:0]             alu_op,
   output logic [7:0]             imm,
   output logic                   acc_we,
   output logic                   enaf,
   output logic                   halted
);
   state_e                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [3:0]             opcode;
   logic [7:0]             imm_f;
   logic                   taken;
   logic                   unused_ir;
   assign opcode    = ir_q[OPC_MSB:OPC_LSB];
   assign imm_f     = ir_q[IMM_MSB:IMM_LSB];
   assign unused_ir = ^ir_q[OPC_LSB-1:IMM_MSB+1];
   branch_cond u_branch_cond (
      .opcode (opcode),
      .C      (C),
      .N      (N),
      .P      (P),
      .Z      (Z),
      .taken  (taken)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
      end
   end
   // flags are sampled live in EXECUTE so a preceding flag update is already visible
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      case (state_q)
         S_FETCH: begin
            state_d = run ? S_DECODE : S_FETCH;
            ir_d    = run ? instr : ir_q;
         end
         S_DECODE: state_d = S_EXECUTE;
         S_EXECUTE: begin
            state_d = (opcode == OP_HLT) ? S_HALT : S_FETCH;
            pc_d    = (opcode == OP_HLT) ? pc_q :
                      taken ? ADDR_WIDTH'(imm_f) : pc_q + ADDR_WIDTH'(1);
         end
         default: state_d = S_HALT;
      endcase
   end
   always_comb begin
      alu_op = (state_q == S_EXECUTE) ? opcode : 4'h0;
      acc_we = (state_q == S_EXECUTE) && writes_acc(opcode);
      enaf   = (state_q == S_EXECUTE) && writes_flags(opcode);
      halted = (state_q == S_HALT);
   end
   assign pc  = pc_q;
   assign imm = imm_f;
endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, program-counter and instruction-address width.
REQ-002 Parameter INSTR_WIDTH, default 16: opcode in [15:12], immediate in [7:0], bits [11:8] ignored.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  when low, FSM holds in FETCH (stall), no outputs asserted.
REQ-006 instr  input  INSTR_WIDTH  instruction word from combinational ROM, addressed by pc.
REQ-007 C, N, P, Z  input  1 each  flags from the flag register (carry, negative, even parity, zero).
REQ-008 pc  output  ADDR_WIDTH  registered program counter.
REQ-009 alu_op  output  4  opcode of current instruction, valid in EXECUTE, 0 otherwise.
REQ-010 imm  output  8  immediate field of instruction register.
REQ-011 acc_we  output  1  accumulator write strobe, one cycle.
REQ-012 enaf  output  1  flag-register update enable, one cycle.
REQ-013 halted  output  1  high while in HALT.

Function
REQ-014 States: FETCH, DECODE, EXECUTE, HALT; every non-halt instruction takes exactly 3 cycles.
REQ-015 FETCH: if run=1, IR <= instr at clock edge, go to DECODE; if run=0, stay in FETCH, IR unchanged.
REQ-016 DECODE -> EXECUTE unconditionally; no outputs asserted in DECODE.
REQ-017 Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 CMP, 8 JMP, 9 JC, A JZ, B JN, C JP, D/E reserved (execute as NOP), F HLT.
REQ-018 EXECUTE, opcodes 1-6: acc_we=1 for one cycle; enaf=1 for opcodes 2-6 only.
REQ-019 EXECUTE, opcode 7 (CMP): enaf=1, acc_we=0.
REQ-020 Branch condition sampled from flag inputs during EXECUTE: JMP always; JC if C; JZ if Z; JN if N; JP if P.
REQ-021 End of EXECUTE: taken branch pc <= imm[ADDR_WIDTH-1:0]; otherwise pc <= pc+1 modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
REQ-022 Branch/NOP/reserved/HLT: acc_we=0, enaf=0.
REQ-023 HLT: at end of EXECUTE go to HALT, pc unchanged; HALT is exited only by rst; run ignored in HALT.
REQ-025 All outputs decoded from registered state and IR only; no combinational path from run, instr or flags to any output.
REQ-026 Flags written by enaf in one instruction's EXECUTE are visible to a branch in the immediately following instruction.
REQ-027 run deasserted outside FETCH has no effect; the current instruction completes.

Reset
REQ-028 rst=1 asynchronously forces state FETCH, pc=0, IR=0, acc_we=0, enaf=0, alu_op=0, imm=0, halted=0.
REQ-029 Reset asserted mid-instruction aborts it; no acc_we or enaf pulse is produced after rst rises.
REQ-030 After rst falls, first fetch occurs at the first rising edge with run=1.

Structure
REQ-031 Shared package/include holds opcode constants, state encoding (2-bit), and INSTR field positions.
REQ-032 One sub-module branch_cond: combinational, inputs opcode and C/N/P/Z, output taken.
REQ-033 Instruction register and pc live in cpu_control_fsm; no other sub-modules.

Verification
REQ-034 Program {LDI 0x05; ADD 0xFB; JZ 0x10}, flag model Z=1 after ADD -> acc_we in cycles 3 and 6, enaf only in cycle 6, pc=0x10 after cycle 9.
REQ-035 {CMP 0x00; JC 0x20} with C=0 -> enaf pulse, no acc_we, pc=0x02 after branch.
REQ-036 pc=0xFF holding NOP -> pc=0x00 after EXECUTE.
REQ-037 run=0 for 5 cycles in FETCH -> pc, IR stable, no strobes; run=1 resumes at same pc.
REQ-038 HLT at pc=0x03 -> halted=1, pc stays 0x03 for 20 cycles regardless of run; rst returns pc=0, halted=0.
REQ-039 rst asserted during EXECUTE of ADD -> acc_we and enaf drop immediately, pc=0, state FETCH.
